// File: rtl/rs232_rx_if.sv
// -----------------------------------------------------------------------------
// rs232_rx_if
// Holding-register side of the RS232 receiver: received byte, its valid/ack
// handshake and the one-cycle error strobes.
//
// Signals:
//   data_out    received byte, stable while data_valid is high
//   data_valid  level, a byte is waiting in the holding register
//   data_ack    consumer pulse, clears data_valid
//   frame_err   one-cycle pulse, stop bit sampled low
//   parity_err  one-cycle pulse, parity mismatch (always 0 without parity)
//   overrun     one-cycle pulse, byte completed while holding register full
//
// Modports:
//   master  receiver side (drives data and strobes, reads data_ack)
//   slave   consumer side (reads data and strobes, drives data_ack)
// -----------------------------------------------------------------------------
interface rs232_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ack;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output parity_err,
        output overrun,
        input  data_ack
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  parity_err,
        input  overrun,
        output data_ack
    );
endinterface

// File: rtl/rs232_rx.sv
// -----------------------------------------------------------------------------
// rs232_rx
// Asynchronous serial receiver with 8x oversampling. Recovers LSB-first frames
// (start, DATA_BITS data bits, optional even parity, one stop bit) from rxd,
// using the 8x-baud strobe rx_en, and hands bytes to a valid/ack holding
// register with framing, parity and overrun error strobes.
//
// Optional feature: define RS232_RX_PARITY_EN to receive one even-parity bit
// between the last data bit and the stop bit. Without it the frame is 8N1
// and parity_err is tied low.
//
// Ports:
//   clk    in   receiver clock
//   reset  in   synchronous, active-low reset
//   rx_en  in   8x-baud sample strobe, one clk cycle wide
//   rxd    in   serial input, idle high, asynchronous to clk
//   busy   out  high whenever the receiver is not idle
//   bus    rs232_rx_if.master  holding register and error strobes
// -----------------------------------------------------------------------------
module rs232_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       rxd,
    output logic       busy,
    rs232_rx_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 sync1_q, sync2_q;
    logic                 rxd_s;
    logic                 stop_hit;
    logic                 frame_good;
    logic                 frame_bad;
    logic                 par_ok;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q;
    logic                 ovr_q, ovr_d;

`ifdef RS232_RX_PARITY_EN
    logic par_q, par_d;
    logic perr_q;
    logic par_bad;

    // Even parity: data bits plus parity bit carry an even number of ones.
    function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] d,
                                            input logic p);
        return ~(^{d, p});
    endfunction
`endif

    // Two-flop synchronizer; both flops come out of reset at the idle level
    // so no false start bit is seen after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    assign rxd_s = sync2_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef RS232_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef RS232_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Start bit is checked on the 4th strobe after detection (its centre);
    // every later bit is sampled when cnt wraps 7->0, i.e. 8 strobes later.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        stop_hit = 1'b0;
`ifdef RS232_RX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_en && !rxd_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (rx_en) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        if (rxd_s) begin
                            // Line went back high: a glitch, not a start bit.
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            cnt_d   = '0;
                            idx_d   = '0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_en) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        // LSB arrives first, so shift in from the top.
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        if (idx_q == LAST_IDX) begin
`ifdef RS232_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end
            S_PARITY: begin
`ifdef RS232_RX_PARITY_EN
                if (rx_en) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        par_d   = rxd_s;
                        state_d = S_STOP;
                    end
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_STOP: begin
                if (rx_en) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        stop_hit = 1'b1;
                        // A low stop bit means a break or a lost frame; wait
                        // for the line to return high before hunting again.
                        state_d  = rxd_s ? S_IDLE : S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_en && rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef RS232_RX_PARITY_EN
    assign par_ok  = even_parity_ok(shift_q, par_q);
    assign par_bad = stop_hit & rxd_s & ~par_ok;
`else
    assign par_ok  = 1'b1;
`endif

    assign frame_good = stop_hit & rxd_s & par_ok;
    assign frame_bad  = stop_hit & ~rxd_s;

    // Holding register: an ack in the delivery cycle frees the slot for the
    // new byte; otherwise a full register drops the new byte as overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (frame_good) begin
            if (!valid_q || bus.data_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (bus.data_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= frame_bad;
            ovr_q   <= ovr_d;
`ifdef RS232_RX_PARITY_EN
            perr_q  <= par_bad;
`endif
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
`ifdef RS232_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_rs232_rx.sv
`timescale 1ns/1ps
module tb_rs232_rx;
    localparam int DATA_BITS = 8;
`ifdef RS232_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB       = 1 + DATA_BITS + PAR + 1;
    localparam int BIT_CLK  = 72;
    // Stop-bit sample edge, counted from the negedge on which the start bit is
    // driven (that negedge directly follows a strobe edge): 2 sync cycles,
    // detect on next strobe (+9), 4 strobes to mid start (+36), then 8 strobes
    // per bit.
    localparam int STOP_POS = 9 + 36 + BIT_CLK * (NB - 1);

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic rx_en = 1'b0;
    logic rxd   = 1'b1;
    logic busy;

    rs232_rx_if #(.DATA_BITS(DATA_BITS)) bus ();

    rs232_rx #(.DATA_BITS(DATA_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .rx_en (rx_en),
        .rxd   (rxd),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int phase  = 0;
    int cyc    = 0;
    int cyc0   = 0;
    int last_ev_cyc = -1;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int ovr_cnt  = 0;
    bit busy_seen = 1'b0;
    logic [DATA_BITS-1:0] exp_q[$];
    logic                 prev_dv   = 1'b0;
    logic [DATA_BITS-1:0] prev_dout = '0;
    logic                 prev_ferr = 1'b0;
    logic                 prev_perr = 1'b0;
    logic                 prev_ovr  = 1'b0;

    // One clock: sample outputs on the falling edge, score new bytes against
    // the expected queue, count error pulses, then drive the next strobe.
    task automatic tick();
        logic [DATA_BITS-1:0] e;
        @(negedge clk);
        cyc++;
        if (bus.data_valid && (!prev_dv || bus.data_out != prev_dout)) begin
            last_ev_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte got %h required none", bus.data_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.data_out !== e) begin
                    errors++;
                    $display("FAIL byte got %h required %h", bus.data_out, e);
                end
            end
        end
        if (bus.frame_err) begin
            ferr_cnt++;
            checks++;
            if (prev_ferr) begin
                errors++;
                $display("FAIL frame_err_width got >1 cycle required 1");
            end
        end
        if (bus.parity_err) begin
            perr_cnt++;
            checks++;
            if (prev_perr) begin
                errors++;
                $display("FAIL parity_err_width got >1 cycle required 1");
            end
        end
        if (bus.overrun) begin
            ovr_cnt++;
            checks++;
            if (prev_ovr) begin
                errors++;
                $display("FAIL overrun_width got >1 cycle required 1");
            end
        end
        if (busy) busy_seen = 1'b1;
        prev_dv   = bus.data_valid;
        prev_dout = bus.data_out;
        prev_ferr = bus.frame_err;
        prev_perr = bus.parity_err;
        prev_ovr  = bus.overrun;
        phase = (phase == 8) ? 0 : phase + 1;
        rx_en = (phase == 0);
    endtask

    // Wait for a strobe edge, then return on the negedge just after it.
    task automatic align_strobe();
        do tick(); while (!rx_en);
        tick();
    endtask

    task automatic pulse_ack();
        bus.data_ack = 1'b1;
        tick();
        bus.data_ack = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] data, input bit stop_bit,
                              input bit bad_par, input bit ack_at_stop, input int rst_at);
        logic [NB-1:0] fb;
        fb[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) fb[1+i] = data[i];
`ifdef RS232_RX_PARITY_EN
        fb[NB-2] = (^data) ^ bad_par;
`endif
        fb[NB-1] = stop_bit;
        align_strobe();
        cyc0 = cyc;
        for (int j = 0; j < NB * BIT_CLK; j++) begin
            if (j % BIT_CLK == 0) rxd = fb[j / BIT_CLK];
            if (ack_at_stop && j == STOP_POS - 1) bus.data_ack = 1'b1;
            if (j == STOP_POS) bus.data_ack = 1'b0;
            if (j == rst_at) reset = 1'b0;
            if (rst_at >= 0 && j == rst_at + 1) begin
                reset = 1'b1;
                checks++;
                if ({busy, bus.data_valid, bus.frame_err, bus.parity_err, bus.overrun, bus.data_out} !== '0) begin
                    errors++;
                    $display("FAIL midframe_reset_outputs got busy=%b dv=%b fe=%b pe=%b ov=%b dout=%h required all 0",
                             busy, bus.data_valid, bus.frame_err, bus.parity_err, bus.overrun, bus.data_out);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rxd = 1'b1;
        bus.data_ack = 1'b0;
        repeat (4) tick();
        checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b required 0", bus.data_valid); end
        checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL reset_dout got %h required 00", bus.data_out); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b required 0", bus.frame_err); end
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b required 0", bus.parity_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b required 0", bus.overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        reset = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_basic();
        logic [DATA_BITS-1:0] pats [3] = '{8'h5A, 8'h81, 8'h00};
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        int p0 = perr_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
        checks++;
        if (last_ev_cyc - cyc0 != STOP_POS) begin
            errors++;
            $display("FAIL basic_latency got %0d required %0d", last_ev_cyc - cyc0, STOP_POS);
        end
        checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hA5) begin errors++; $display("FAIL basic_hold got dv=%b dout=%h required 1/a5", bus.data_valid, bus.data_out); end
        checks++; if (ferr_cnt != f0 || ovr_cnt != o0 || perr_cnt != p0) begin errors++; $display("FAIL basic_errs got fe=%0d ov=%0d pe=%0d required none", ferr_cnt - f0, ovr_cnt - o0, perr_cnt - p0); end
        pulse_ack();
        checks++; if (bus.data_valid !== 1'b0 || bus.data_out !== 8'hA5) begin errors++; $display("FAIL basic_ack got dv=%b dout=%h required 0/a5", bus.data_valid, bus.data_out); end
        foreach (pats[k]) begin
            exp_q.push_back(pats[k]);
            send_frame(pats[k], 1'b1, 1'b0, 1'b0, -1);
            checks++; if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL pattern_dv got %b required 1", bus.data_valid); end
            pulse_ack();
        end
    endtask

    task automatic test_glitch();
        logic [DATA_BITS-1:0] d0 = bus.data_out;
        int f0 = ferr_cnt;
        busy_seen = 1'b0;
        align_strobe();
        rxd = 1'b0;
        repeat (20) tick();
        rxd = 1'b1;
        repeat (80) tick();
        checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_start got busy_seen=%b required 1", busy_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got busy=%b required 0", busy); end
        checks++; if (bus.data_valid !== 1'b0 || bus.data_out !== d0 || ferr_cnt != f0) begin errors++; $display("FAIL glitch_outputs got dv=%b dout=%h fe=%0d required 0/%h/0", bus.data_valid, bus.data_out, ferr_cnt - f0, d0); end
    endtask

    task automatic test_framing_break();
        int f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
        repeat (3 * BIT_CLK) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_hold got busy=%b required 1", busy); end
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL frame_err_count got %0d required 1", ferr_cnt - f0); end
        checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL break_dv got %b required 0", bus.data_valid); end
        rxd = 1'b1;
        repeat (BIT_CLK) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_exit got busy=%b required 0", busy); end
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, -1);
        checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h55) begin errors++; $display("FAIL after_break got dv=%b dout=%h required 1/55", bus.data_valid, bus.data_out); end
        pulse_ack();
    endtask

    task automatic test_back_to_back();
        int o0 = ovr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, -1);
        checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h11) begin errors++; $display("FAIL overrun_hold got dv=%b dout=%h required 1/11", bus.data_valid, bus.data_out); end
        checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL overrun_count got %0d required 1", ovr_cnt - o0); end
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, 1'b0, 1'b1, -1);
        checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h33) begin errors++; $display("FAIL ack_same_cycle got dv=%b dout=%h required 1/33", bus.data_valid, bus.data_out); end
        checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL ack_same_cycle_ovr got %0d required 1", ovr_cnt - o0); end
        checks++; if (last_ev_cyc - cyc0 != STOP_POS) begin errors++; $display("FAIL ack_same_cycle_lat got %0d required %0d", last_ev_cyc - cyc0, STOP_POS); end
        pulse_ack();
        checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack got dv=%b required 0", bus.data_valid); end
    endtask

    task automatic test_midframe_reset();
        // Bit 4 spans offsets 360..431 from the start edge.
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 380);
        repeat (20) tick();
        checks++; if (bus.data_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_abort got dv=%b busy=%b required 0/0", bus.data_valid, busy); end
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0, -1);
        checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h0F) begin errors++; $display("FAIL after_reset got dv=%b dout=%h required 1/0f", bus.data_valid, bus.data_out); end
        pulse_ack();
    endtask

`ifdef RS232_RX_PARITY_EN
    task automatic test_parity();
        int p0 = perr_cnt;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, -1);
        checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h07 || perr_cnt != p0) begin errors++; $display("FAIL parity_good got dv=%b dout=%h pe=%0d required 1/07/0", bus.data_valid, bus.data_out, perr_cnt - p0); end
        pulse_ack();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1);
        checks++; if (perr_cnt - p0 != 1) begin errors++; $display("FAIL parity_err_count got %0d required 1", perr_cnt - p0); end
        checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL parity_bad_dv got %b required 0", bus.data_valid); end
    endtask
`endif

    initial begin
        bus.data_ack = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_framing_break();
        test_back_to_back();
        test_midframe_reset();
`ifdef RS232_RX_PARITY_EN
        test_parity();
`else
        checks++; if (perr_cnt != 0) begin errors++; $display("FAIL parity_tied got %0d pulses required 0", perr_cnt); end
`endif
        repeat (10) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_bytes got %0d undelivered required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
